// File: rtl/stream_io_bridge.sv
// AXI-Stream bridge: parses a length header, forwards payload to a compute core,
// and buffers core results in a FIFO for a TLAST-terminated output packet.
module stream_io_bridge #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic                AXIS_ACLK,
    input  logic                AXIS_ARESET,
    input  logic [DATA_W-1:0]   S_AXIS_TDATA,
    input  logic [DATA_W/8-1:0] S_AXIS_TKEEP,
    input  logic                S_AXIS_TLAST,
    input  logic                S_AXIS_TVALID,
    output logic                S_AXIS_TREADY,
    output logic [DATA_W-1:0]   M_AXIS_TDATA,
    output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
    output logic                M_AXIS_TLAST,
    output logic                M_AXIS_TVALID,
    input  logic                M_AXIS_TREADY,
    output logic [DATA_W-1:0]   core_x_data,
    output logic                core_x_valid,
    input  logic                core_x_ready,
    input  logic [DATA_W-1:0]   core_y_data,
    input  logic                core_y_valid,
    output logic                core_y_ready,
    input  logic [CNT_W-1:0]    core_ycnt,
    input  logic                core_ycnt_valid,
    output logic                busy,
    output logic                err_len
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IN_HDR, IN_PAY, IN_DRAIN} in_state_t;
    typedef enum logic {OUT_IDLE, OUT_RUN} out_state_t;

    in_state_t         in_state;
    out_state_t        out_state;
    logic [CNT_W-1:0]  in_rem;
    logic [CNT_W-1:0]  out_rem;
    logic [AW:0]       wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic              full_q;
    logic              empty;
    logic              rx, push, pop;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              unused_keep;

    assign unused_keep = ^S_AXIS_TKEEP;

    // Input side is combinational so payload reaches the core with zero latency.
    always_comb begin
        S_AXIS_TREADY = 1'b1;
        if (in_state == IN_PAY)
            S_AXIS_TREADY = core_x_ready;
        if (AXIS_ARESET)
            S_AXIS_TREADY = 1'b0;
    end

    assign core_x_data  = S_AXIS_TDATA;
    assign core_x_valid = (in_state == IN_PAY) & S_AXIS_TVALID;
    assign rx           = S_AXIS_TVALID & S_AXIS_TREADY;

    assign empty         = (wr_ptr == rd_ptr);
    assign core_y_ready  = ~full_q;
    assign push          = core_y_valid & ~full_q;
    assign M_AXIS_TVALID = (out_state == OUT_RUN) & ~empty;
    assign M_AXIS_TDATA  = mem[rd_ptr[AW-1:0]];
    assign M_AXIS_TLAST  = M_AXIS_TVALID & (out_rem == CNT_W'(1));
    assign M_AXIS_TKEEP  = M_AXIS_TVALID ? '1 : '0;
    assign pop           = M_AXIS_TVALID & M_AXIS_TREADY;
    assign wr_ptr_n      = wr_ptr + (AW+1)'(push);
    assign rd_ptr_n      = rd_ptr + (AW+1)'(pop);

    assign busy = (in_state != IN_HDR) | (out_state != OUT_IDLE) | ~empty;

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            in_state <= IN_HDR;
            in_rem   <= '0;
            err_len  <= 1'b0;
        end else if (rx) begin
            case (in_state)
                IN_HDR: begin
                    in_rem  <= S_AXIS_TDATA[CNT_W-1:0];
                    err_len <= 1'b0;
                    if (S_AXIS_TDATA[CNT_W-1:0] == '0)
                        in_state <= S_AXIS_TLAST ? IN_HDR : IN_DRAIN;
                    else
                        in_state <= IN_PAY;
                end
                IN_PAY: begin
                    if (in_rem != '0)
                        in_rem <= in_rem - CNT_W'(1);
                    if (in_rem == CNT_W'(1)) begin
                        in_state <= S_AXIS_TLAST ? IN_HDR : IN_DRAIN;
                        if (!S_AXIS_TLAST)
                            err_len <= 1'b1;
                    end else if (S_AXIS_TLAST) begin
                        in_state <= IN_HDR;
                        err_len  <= 1'b1;
                    end
                end
                IN_DRAIN: begin
                    if (S_AXIS_TLAST)
                        in_state <= IN_HDR;
                end
                default: in_state <= IN_HDR;
            endcase
        end
    end

    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            out_state <= OUT_IDLE;
            out_rem   <= '0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (core_ycnt_valid && core_ycnt != '0) begin
                        out_rem   <= core_ycnt;
                        out_state <= OUT_RUN;
                    end
                end
                OUT_RUN: begin
                    if (pop) begin
                        if (out_rem != '0)
                            out_rem <= out_rem - CNT_W'(1);
                        if (out_rem == CNT_W'(1))
                            out_state <= OUT_IDLE;
                    end
                end
                default: out_state <= OUT_IDLE;
            endcase
        end
    end

    // Full flag is registered from next-state pointers so core_y_ready is a clean flop.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full_q <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            full_q <= ((wr_ptr_n ^ rd_ptr_n) == {1'b1, {AW{1'b0}}});
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= core_y_data;
    end
endmodule

// File: doc/stream_io_bridge.md
# stream_io_bridge

Parametrised AXI-Stream bridge between the DMA engine and a compute core, succeeding the fixed 32-bit pairwise bridge. Parses a length header on the slave stream and forwards exactly that many payload words to the core with a valid/ready handshake. Buffers core results in a FIFO of configurable depth and emits them on the master stream with TLAST on the exact final word of a core-declared output count. It also detects and recovers from input length mismatches.

## Interface
- DATA_W, 32, stream and core data width in bits; multiple of 8.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥2.
- CNT_W, 32, width of the header and output counters; ≤ DATA_W.
- AXIS_ACLK  in  1  single clock for all logic.
- AXIS_ARESET  in  1  asynchronous, active-high reset.
- S_AXIS_TDATA  in  DATA_W  header or payload word.
- S_AXIS_TKEEP  in  DATA_W/8  ignored.
- S_AXIS_TLAST  in  1  end of input packet.
- S_AXIS_TVALID  in  1  input word valid.
- S_AXIS_TREADY  out  1  bridge accepts an input word.
- M_AXIS_TDATA  out  DATA_W  result word, the FIFO head.
- M_AXIS_TKEEP  out  DATA_W/8  all ones when M_AXIS_TVALID=1, else 0.
- M_AXIS_TLAST  out  1  final word of the output packet.
- M_AXIS_TVALID  out  1  result word valid.
- M_AXIS_TREADY  in  1  DMA accepts a result word.
- core_x_data  out  DATA_W  payload to the core.
- core_x_valid  out  1  payload valid.
- core_x_ready  in  1  core accepts payload.
- core_y_data  in  DATA_W  core result.
- core_y_valid  in  1  result valid.
- core_y_ready  out  1  FIFO not full.
- core_ycnt  in  CNT_W  number of results in the next output packet.
- core_ycnt_valid  in  1  core_ycnt is valid.
- busy  out  1  packet in flight or FIFO non-empty.
- err_len  out  1  sticky input length mismatch flag.

## Operation
- Transfer definitions: RX = S_AXIS_TVALID & S_AXIS_TREADY; TX = M_AXIS_TVALID & M_AXIS_TREADY; PUSH = core_y_valid & core_y_ready.
- Input FSM IN_HDR → IN_PAY → IN_DRAIN; reset state is IN_HDR.
  - IN_HDR:
    - S_AXIS_TREADY=1.
    - On RX, in_rem ← TDATA[CNT_W-1:0] and err_len clears.
    - If the header is 0 with TLAST → stay in IN_HDR.
    - If the header is 0 without TLAST → IN_DRAIN.
    - Otherwise → IN_PAY.
  - IN_PAY:
    - Combinational pass-through: core_x_data=S_AXIS_TDATA, core_x_valid=S_AXIS_TVALID, S_AXIS_TREADY=core_x_ready.
    - Each RX decrements in_rem.
    - RX with in_rem==1 and TLAST → IN_HDR.
    - RX with in_rem==1 and no TLAST → IN_DRAIN, set err_len.
    - RX with TLAST and in_rem>1 → IN_HDR, set err_len (short packet; the core receives the words already sent).
  - IN_DRAIN:
    - S_AXIS_TREADY=1, core_x_valid=0, words are discarded.
    - RX with TLAST → IN_HDR.
- core_x_valid=0 outside IN_PAY.
- Output FIFO:
  - FIFO_DEPTH entries; pointers are log2(FIFO_DEPTH)+1 bits for full/empty detection.
  - core_y_ready = !full, registered from the pointers.
  - M_AXIS_TDATA = mem[rd_ptr].
  - A push and a pop in the same cycle are both performed; the count is unchanged.
- Output FSM OUT_IDLE / OUT_RUN; reset state is OUT_IDLE.
  - OUT_IDLE: M_AXIS_TVALID=0. core_ycnt_valid with core_ycnt≠0 loads out_rem and → OUT_RUN. core_ycnt=0 is ignored. Results may be pushed into the FIFO before a count arrives.
  - OUT_RUN: M_AXIS_TVALID=!empty; M_AXIS_TLAST = M_AXIS_TVALID & (out_rem==1). Each TX decrements out_rem. TX with out_rem==1 → OUT_IDLE. core_ycnt_valid is ignored in OUT_RUN.
- busy = (in_state≠IN_HDR) | (out_state≠OUT_IDLE) | !empty.
- Counters never wrap. in_rem and out_rem only decrement while nonzero.

## Timing
- Reset (asynchronous) values:
  - FIFO empty, pointers 0.
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TKEEP=0.
  - core_x_valid=0, core_y_ready=1.
  - busy=0, err_len=0.
  - S_AXIS_TREADY is forced to 0 while AXIS_ARESET=1 and becomes 1 in the first cycle after release.
- A reset mid-packet discards FIFO contents and all counts. The next input word is treated as a header.
- Input-to-core latency: 0 cycles (combinational).
- Core-to-master latency: a PUSH at edge t gives M_AXIS_TVALID at t+1 if in OUT_RUN and the FIFO was empty.
- core_y_ready reflects occupancy after edge t. A push in a full cycle cannot occur, even with a concurrent pop; the slot is freed on the next cycle.
- Sustained throughput is 1 word/cycle on both streams when the sinks are ready.
- M_AXIS_TDATA, M_AXIS_TLAST and M_AXIS_TVALID hold stable while TVALID=1 and TREADY=0.

## Test plan
- Header 4, payload 10,20,30,40 with TLAST on 40; identity core; core_ycnt=4 → core sees 4 words; M outputs 10,20,30,40 with TLAST only on 40; err_len=0; busy returns to 0.
- FIFO_DEPTH=4, M_AXIS_TREADY low for 8 cycles then toggling every cycle, 6 results → core_y_ready drops after 4 pushes; all 6 words emerge in order; TLAST on the 6th; TDATA stable while stalled.
- Header 5, TLAST on the 3rd payload word → err_len=1; next header accepted; the following good packet clears err_len.
- Header 2, payload of 4 words with TLAST on the 4th → core sees 2 words; 2 words dropped; err_len=1; S_AXIS_TREADY=1 during drain.
- Header 0 with TLAST, then core_ycnt=0 → no core_x_valid, no M transfers, busy stays 0.
- Reset asserted after 2 of 4 payload words and 1 result in the FIFO → all outputs go to reset values immediately; after release, a fresh header-3 packet completes correctly.
